// File: rtl/vdp_pkg.sv
// Shared VDP encodings: CPU access codes carried in the second control byte
// and the CPU-port VRAM sequencer states.
package vdp_pkg;

    localparam logic [1:0] CODE_VRAM_RD = 2'd0;
    localparam logic [1:0] CODE_VRAM_WR = 2'd1;
    localparam logic [1:0] CODE_REG_WR  = 2'd2;
    localparam logic [1:0] CODE_CRAM_WR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_CAP  = 2'd3
    } cpu_state_e;

endpackage

// File: rtl/vdp_cpu_port.sv
// VDP CPU interface: two-byte control protocol, data port with read-ahead
// buffer, and a grant-paced VRAM access sequencer.
module vdp_cpu_port
    import vdp_pkg::*;
#(
    parameter int CRAM_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_port,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    input  logic              vram_grant,
    output logic [13:0]       vram_a,
    output logic              vram_we,
    output logic [7:0]        vram_dout,
    input  logic [7:0]        vram_din,
    output logic              cram_we,
    output logic [4:0]        cram_a,
    output logic [CRAM_W-1:0] cram_d,
    output logic              reg_we,
    output logic [3:0]        reg_num,
    output logic [7:0]        reg_d
);

    cpu_state_e        state_q, state_d;
    logic [13:0]       addr_q, addr_d;
    logic [1:0]        code_q, code_d;
    logic              flag_q, flag_d;
    logic [7:0]        latch_q, latch_d;
    logic [7:0]        rbuf_q, rbuf_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              reg_we_q, reg_we_d;
    logic [3:0]        reg_num_q, reg_num_d;
    logic [7:0]        reg_d_q, reg_d_d;
    logic              cram_we_q, cram_we_d;
    logic [4:0]        cram_a_q, cram_a_d;
    logic [CRAM_W-1:0] cram_d_q, cram_d_d;

    // Strobes are only honoured when idle; a write wins over a simultaneous read.
    logic wr_acc, rd_acc;
    assign wr_acc = cpu_wr && (state_q == ST_IDLE);
    assign rd_acc = cpu_rd && !cpu_wr && (state_q == ST_IDLE);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        code_d    = code_q;
        flag_d    = flag_q;
        latch_d   = latch_q;
        rbuf_d    = rbuf_q;
        wdata_d   = wdata_q;
        reg_we_d  = 1'b0;
        reg_num_d = reg_num_q;
        reg_d_d   = reg_d_q;
        cram_we_d = 1'b0;
        cram_a_d  = cram_a_q;
        cram_d_d  = cram_d_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc && cpu_port && !flag_q) begin
                    latch_d     = cpu_din;
                    addr_d[7:0] = cpu_din;
                    flag_d      = 1'b1;
                end else if (wr_acc && cpu_port) begin
                    code_d       = cpu_din[7:6];
                    addr_d[13:8] = cpu_din[5:0];
                    flag_d       = 1'b0;
                    if (cpu_din[7:6] == CODE_REG_WR) begin
                        reg_we_d  = 1'b1;
                        reg_num_d = cpu_din[3:0];
                        reg_d_d   = latch_q;
                    end else if (cpu_din[7:6] == CODE_VRAM_RD) begin
                        state_d = ST_RD_WAIT;
                    end
                end else if (wr_acc) begin
                    flag_d = 1'b0;
                    if (code_q == CODE_CRAM_WR) begin
                        cram_we_d = 1'b1;
                        cram_a_d  = addr_q[4:0];
                        cram_d_d  = cpu_din[CRAM_W-1:0];
                        addr_d    = addr_q + 14'd1;
                    end else begin
                        wdata_d = cpu_din;
                        rbuf_d  = cpu_din;
                        state_d = ST_WR_WAIT;
                    end
                end else if (rd_acc) begin
                    flag_d = 1'b0;
                    if (!cpu_port) state_d = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (vram_grant) begin
                    addr_d  = addr_q + 14'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (vram_grant) state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                rbuf_d  = vram_din;
                addr_d  = addr_q + 14'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            code_q    <= '0;
            flag_q    <= 1'b0;
            latch_q   <= '0;
            rbuf_q    <= '0;
            wdata_q   <= '0;
            reg_we_q  <= 1'b0;
            reg_num_q <= '0;
            reg_d_q   <= '0;
            cram_we_q <= 1'b0;
            cram_a_q  <= '0;
            cram_d_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            code_q    <= code_d;
            flag_q    <= flag_d;
            latch_q   <= latch_d;
            rbuf_q    <= rbuf_d;
            wdata_q   <= wdata_d;
            reg_we_q  <= reg_we_d;
            reg_num_q <= reg_num_d;
            reg_d_q   <= reg_d_d;
            cram_we_q <= cram_we_d;
            cram_a_q  <= cram_a_d;
            cram_d_q  <= cram_d_d;
        end
    end

    assign cpu_dout  = rbuf_q;
    assign busy      = (state_q != ST_IDLE);
    assign vram_a    = addr_q;
    assign vram_we   = (state_q == ST_WR_WAIT) && vram_grant;
    assign vram_dout = wdata_q;
    assign cram_we   = cram_we_q;
    assign cram_a    = cram_a_q;
    assign cram_d    = cram_d_q;
    assign reg_we    = reg_we_q;
    assign reg_num   = reg_num_q;
    assign reg_d     = reg_d_q;

endmodule
